instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential word-address PC, 2-entry {instr, pc} skid FIFO, redirect flush.
// Optional perf counters (perf_fetched, perf_stall) built when IFETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd,
    output logic        mem_wn,
    output logic [15:0] mem_address,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [15:0] fetch_pc;
    logic [15:0] pend_pc;
    logic        pending;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] instr_q [2];
    logic [15:0] pc_q    [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    assign pop       = id_valid & id_ready;
    assign occupancy = {1'b0, count} + {2'b00, pending};
    // The pending read always has a slot reserved, so count + pending never exceeds 2.
    assign issue     = rst_n & !redirect_valid & (occupancy < (3'd2 + {2'b00, pop}));
    assign push      = pending & !redirect_valid;
    assign wr_ptr    = rd_ptr ^ count[0];

    assign mem_rd      = issue;
    assign mem_wn      = 1'b0;
    assign mem_address = fetch_pc;

    assign id_valid = (count != 2'd0);
    assign id_instr = id_valid ? instr_q[rd_ptr] : 32'h0;
    assign id_pc    = id_valid ? pc_q[rd_ptr]    : 16'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            pending  <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            pending  <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (issue) begin
            pend_pc <= fetch_pc;
        end
        if (push) begin
            instr_q[wr_ptr] <= mem_read_data;
            pc_q[wr_ptr]    <= pend_pc;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (id_valid & !id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table for reset release and redirect, hand sequences
// for stall, mid-operation reset and PC wrap, plus a queue scoreboard on every accepted instruction.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wn;
    logic [15:0] mem_address;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [31:0] perf_fetched_b, perf_stall_b;
`endif

    logic        mem_rd_b, mem_wn_b;
    logic [15:0] mem_address_b;
    logic [31:0] mem_read_data_b;
    logic        redirect_valid_b;
    logic [15:0] redirect_pc_b;
    logic        id_valid_b, id_ready_b;
    logic [31:0] id_instr_b;
    logic [15:0] id_pc_b;

    int checks = 0;
    int fails  = 0;
    int pops_b = 0;
    logic [15:0] exp_b = 16'hFFFE;
    logic [15:0] sbq[$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(16'h0010)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
        .mem_read_data(mem_read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_rd(mem_rd_b), .mem_wn(mem_wn_b), .mem_address(mem_address_b),
        .mem_read_data(mem_read_data_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .id_valid(id_valid_b), .id_ready(id_ready_b), .id_instr(id_instr_b), .id_pc(id_pc_b)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched_b), .perf_stall(perf_stall_b)
`endif
    );

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Instruction memory models: one-cycle read latency, poison when no read was strobed.
    always @(posedge clk) begin
        mem_read_data   <= mem_rd   ? memf(mem_address)   : 32'hDEADBEEF;
        mem_read_data_b <= mem_rd_b ? memf(mem_address_b) : 32'hDEADBEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [15:0] start);
        sbq.delete();
        for (int k = 0; k < 256; k++) sbq.push_back(start + 16'(k));
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && id_valid && id_ready) begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'(id_pc), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sbq.pop_front();
                check("sb_id_pc", 32'(id_pc), 32'(e));
                check("sb_id_instr", id_instr, memf(e));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_b = 16'hFFFE;
        end else if (id_valid_b) begin
            check("wrap_id_pc", 32'(id_pc_b), 32'(exp_b));
            check("wrap_id_instr", id_instr_b, memf(exp_b));
            exp_b = exp_b + 16'd1;
            pops_b++;
        end
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0000};
        vt[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b1, 16'h0010};
        vt[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0013, 1'b1, 16'h0011};
        vt[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b1, 16'h0012};
        vt[5] = '{1'b1, 1'b1, 16'h0200, 1'b0, 16'h0015, 1'b1, 16'h0013};
        vt[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 16'h0000};
        vt[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0201, 1'b0, 16'h0000};
        vt[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0202, 1'b1, 16'h0200};

        rst_n = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        id_ready_b = 1'b1;
        redirect_valid_b = 1'b0;
        redirect_pc_b = 16'h0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", 32'(id_pc), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'h0010);

        @(negedge clk);
        rst_n = 1'b1;
        sb_restart(16'h0010);
        for (int i = 0; i < 9; i++) begin
            if (i > 0 && vt[i-1].rv) sb_restart(vt[i-1].rpc);
            id_ready = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc;
            #1;
            check($sformatf("v%0d_mem_rd", i), 32'(mem_rd), 32'(vt[i].e_rd));
            check($sformatf("v%0d_mem_wn", i), 32'(mem_wn), 32'd0);
            check($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(vt[i].e_addr));
            check($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(vt[i].e_v));
            check($sformatf("v%0d_id_pc", i), 32'(id_pc), 32'(vt[i].e_pc));
            check($sformatf("v%0d_id_instr", i), id_instr,
                  vt[i].e_v ? memf(vt[i].e_pc) : 32'd0);
            @(negedge clk);
        end

        // Decode stall: FIFO fills to two, fetch stops, head held.
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d_mem_rd", i), 32'(mem_rd), 32'd0);
            check($sformatf("stall%0d_id_valid", i), 32'(id_valid), 32'd1);
            check($sformatf("stall%0d_id_pc", i), 32'(id_pc), 32'h0201);
            check($sformatf("stall%0d_id_instr", i), id_instr, memf(16'h0201));
            @(negedge clk);
        end
        id_ready = 1'b1;
        #1;
        check("release_mem_rd", 32'(mem_rd), 32'd1);
        check("release_mem_address", 32'(mem_address), 32'h0203);
        repeat (6) @(negedge clk);

        // Reset while entries are buffered.
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_id_pc", 32'(id_pc), 32'd0);
        check("midrst_mem_address", 32'(mem_address), 32'h0010);
        id_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_restart(16'h0010);
        #1;
        check("restart_mem_rd", 32'(mem_rd), 32'd1);
        check("restart_mem_address", 32'(mem_address), 32'h0010);
        repeat (2) @(negedge clk);
        #1;
        check("restart_id_valid", 32'(id_valid), 32'd1);
        check("restart_id_pc", 32'(id_pc), 32'h0010);
        repeat (6) @(negedge clk);

`ifdef IFETCH_PERF_CNT_EN
        rst_n = 1'b0;
        #1;
        check("perf_rst_fetched", perf_fetched, 32'd0);
        check("perf_rst_stall", perf_stall, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_restart(16'h0010);
        repeat (12) @(negedge clk);
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stall", perf_stall, 32'd3);
        @(negedge clk);
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
`endif

        check("wrap_pops_seen", 32'(pops_b >= 3), 32'd1);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
